// File: rtl/pattern_round_engine_pkg.sv
// Shared types and constants for the memory-game pattern round engine.
package pattern_round_engine_pkg;

  localparam int unsigned SYM_W     = 2;
  localparam int unsigned NUM_SYM   = 4;
  localparam int unsigned MAX_LEN   = 8;
  localparam int unsigned BASE_LEN  = 2;
  localparam int unsigned LEVEL_MAX = 5;
  localparam int unsigned LVL_W     = 4;
  localparam int unsigned LEN_W     = 4;
  localparam int unsigned FCNT_W    = 4;
  localparam int unsigned IDX_W     = $clog2(MAX_LEN);
  localparam int unsigned LFSR_W    = 16;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GEN,
    ST_SHOW,
    ST_GAP,
    ST_INPUT,
    ST_WIN,
    ST_LOSE
  } state_t;

  typedef logic [SYM_W-1:0] sym_t;

  // True when exactly the button belonging to symbol s is pressed.
  function automatic logic onehot_match(input logic [NUM_SYM-1:0] b, input sym_t s);
    return b == (NUM_SYM'(1) << s);
  endfunction

endpackage

// File: rtl/pattern_round_engine_if.sv
// Game-side signals of the round engine: level/start/buttons in, display/result out.
interface pattern_round_engine_if;
  import pattern_round_engine_pkg::*;

  logic [LVL_W-1:0]   level_num;
  logic               levelupdated;
  logic               log_out;
  logic               rng_button;
  logic [NUM_SYM-1:0] btn;
  logic               disp_valid;
  sym_t               disp_sym;
  logic               win;
  logic               lose;
  logic               busy;
  logic [FCNT_W-1:0]  fail_cnt;

  modport master (
    output level_num, levelupdated, log_out, rng_button, btn,
    input  disp_valid, disp_sym, win, lose, busy, fail_cnt
  );

  modport slave (
    input  level_num, levelupdated, log_out, rng_button, btn,
    output disp_valid, disp_sym, win, lose, busy, fail_cnt
  );

endinterface

// File: rtl/pattern_round_engine_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11) with external entropy mixed into feedback.
module pattern_round_engine_lfsr16
  import pattern_round_engine_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              en_mix,
  output logic [LFSR_W-1:0] q
);

  logic              fb_c;
  logic [LFSR_W-1:0] nxt_c;

  // Entropy can steer the register into all-zero; reload the seed instead of locking up.
  always_comb begin
    fb_c  = q[15] ^ q[13] ^ q[12] ^ q[10] ^ en_mix;
    nxt_c = {q[LFSR_W-2:0], fb_c};
    if (nxt_c == '0) nxt_c = LFSR_SEED;
  end

  always_ff @(posedge clk) begin
    if (rst) q <= LFSR_SEED;
    else     q <= nxt_c;
  end

endmodule

// File: rtl/pattern_round_engine.sv
// One memory round: generate a random pattern, flash it, then check the player's echo.
module pattern_round_engine
  import pattern_round_engine_pkg::*;
#(
  parameter int unsigned DISP_CYCLES    = 50_000_000,
  parameter int unsigned GAP_CYCLES     = 12_500_000,
  parameter int unsigned TIMEOUT_CYCLES = 250_000_000
) (
  input  logic                  clk,
  input  logic                  rst,
  pattern_round_engine_if.slave bus
);

  localparam int unsigned DISP_W = (DISP_CYCLES > 1)    ? $clog2(DISP_CYCLES)    : 1;
  localparam int unsigned GAP_W  = (GAP_CYCLES > 1)     ? $clog2(GAP_CYCLES)     : 1;
  localparam int unsigned TOUT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned DG_W   = (DISP_W > GAP_W) ? DISP_W : GAP_W;
  localparam int unsigned TMR_W  = (DG_W > TOUT_W) ? DG_W : TOUT_W;

  state_t             state;
  logic [LEN_W-1:0]   len;
  logic [IDX_W-1:0]   idx;
  logic [TMR_W-1:0]   timer;
  sym_t               pat [MAX_LEN];
  logic [LFSR_W-1:0]  lfsr_q;
  logic               last_c;
  logic               unused_lfsr;

  pattern_round_engine_lfsr16 u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .en_mix (bus.rng_button),
    .q      (lfsr_q)
  );

  assign unused_lfsr = ^lfsr_q[LFSR_W-1:SYM_W];
  assign last_c      = (LEN_W'(idx) == len - LEN_W'(1));

  // Pattern regfile; contents are only meaningful after a full GEN pass.
  always_ff @(posedge clk) begin
    if (state == ST_GEN) pat[idx] <= lfsr_q[SYM_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst || bus.log_out) begin
      state          <= ST_IDLE;
      len            <= '0;
      idx            <= '0;
      timer          <= '0;
      bus.disp_valid <= 1'b0;
      bus.disp_sym   <= '0;
      bus.win        <= 1'b0;
      bus.lose       <= 1'b0;
      bus.busy       <= 1'b0;
      bus.fail_cnt   <= '0;
    end else begin
      bus.win  <= 1'b0;
      bus.lose <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.levelupdated && bus.level_num >= LVL_W'(1) &&
              bus.level_num <= LVL_W'(LEVEL_MAX)) begin
            len          <= bus.level_num + LVL_W'(BASE_LEN);
            idx          <= '0;
            bus.fail_cnt <= '0;
            bus.busy     <= 1'b1;
            state        <= ST_GEN;
          end
        end
        ST_GEN: begin
          if (last_c) begin
            idx            <= '0;
            timer          <= '0;
            bus.disp_valid <= 1'b1;
            bus.disp_sym   <= pat[0];
            state          <= ST_SHOW;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        ST_SHOW: begin
          if (timer == TMR_W'(DISP_CYCLES - 1)) begin
            timer          <= '0;
            bus.disp_valid <= 1'b0;
            bus.disp_sym   <= '0;
            state          <= ST_GAP;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        ST_GAP: begin
          if (timer == TMR_W'(GAP_CYCLES - 1)) begin
            timer <= '0;
            if (last_c) begin
              idx   <= '0;
              state <= ST_INPUT;
            end else begin
              idx            <= idx + IDX_W'(1);
              bus.disp_valid <= 1'b1;
              bus.disp_sym   <= pat[idx + IDX_W'(1)];
              state          <= ST_SHOW;
            end
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        ST_INPUT: begin
          // Any nonzero button vector is one entry; multi-hot counts as wrong.
          if (bus.btn != '0) begin
            if (onehot_match(bus.btn, pat[idx])) begin
              timer <= '0;
              if (last_c) begin
                bus.win <= 1'b1;
                state   <= ST_WIN;
              end else begin
                idx <= idx + IDX_W'(1);
              end
            end else begin
              bus.lose <= 1'b1;
              if (bus.fail_cnt != '1) bus.fail_cnt <= bus.fail_cnt + FCNT_W'(1);
              state <= ST_LOSE;
            end
          end else if (timer == TMR_W'(TIMEOUT_CYCLES - 1)) begin
            bus.lose <= 1'b1;
            if (bus.fail_cnt != '1) bus.fail_cnt <= bus.fail_cnt + FCNT_W'(1);
            state <= ST_LOSE;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        ST_WIN: begin
          idx      <= '0;
          bus.busy <= 1'b0;
          state    <= ST_IDLE;
        end
        ST_LOSE: begin
          idx   <= '0;
          timer <= '0;
          state <= ST_GEN;
        end
        default: begin
          bus.busy <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
